key_sched_ctrl: RTL and testbench
=================================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request expansion of key_in; sampled only in IDLE.
REQ-004 abort  input  1  terminate expansion; return to IDLE.
REQ-005 key_in  input  128  cipher key; bits [127:96] are w0, and bits [31:0] are w3.
REQ-006 rk_ready  input  1  consumer accepts rk_out when high with rk_valid.
REQ-007 rk_valid  output  1  rk_out/rk_idx hold a valid round key.
REQ-008 rk_out  output  128  current round key.
REQ-009 rk_idx  output  4  round number of rk_out, 0..10.
REQ-010 busy  output  1  high in EMIT state.
REQ-011 done  output  1  one-cycle pulse after round key 10 is accepted.
REQ-012 rd_idx  input  4  stored-key read address (see Configuration).
REQ-013 rd_key  output  128  stored round key (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, EMIT and DONE.
REQ-015 IDLE with start=1 and abort=0 SHALL load rk_out=key_in and rk_idx=0, set rk_valid=1, and go to EMIT; first valid key 1 cycle after start.
REQ-016 A handshake SHALL occur on any cycle with rk_valid=1 and rk_ready=1.
REQ-017 In EMIT with no handshake, rk_out, rk_idx and rk_valid SHALL hold unchanged (backpressure, unlimited length).
REQ-018 In EMIT, a handshake with rk_idx<10 SHALL load rk_out=next(rk_out) and rk_idx+1; rk_valid stays 1, giving one key per cycle at full throughput.
REQ-019 In EMIT, a handshake with rk_idx=10 SHALL clear rk_valid and go to DONE; done=1 during DONE; DONE SHALL go to IDLE unconditionally after 1 cycle.
REQ-020 next(): g = SubWord(RotWord(w3)) ^ {Rcon[rk_idx],24'h0}, where RotWord(w) = {w[23:0],w[31:24]} and SubWord is the AES S-box applied per byte; n0=w0^g, n1=w1^n0, n2=w2^n1, n3=w3^n2.
REQ-021 Rcon[0..9] SHALL be 01,02,04,08,10,20,40,80,1b,36; the Rcon path SHALL be 0 for rk_idx>9.
REQ-022 next() SHALL be a single-cycle combinational path from the rk_out register, using one g-function instance.
REQ-023 start in EMIT or DONE SHALL be ignored, with no effect on state or outputs.
REQ-024 abort=1 in EMIT or DONE SHALL force IDLE next cycle with rk_valid=0 and done=0; a handshake in the same cycle is still counted by the consumer, but no further key is produced.
REQ-025 abort=1 together with start=1 in IDLE: abort SHALL win and the FSM stays in IDLE.
REQ-026 In IDLE, rk_out and rk_idx SHALL hold their last values and rk_valid=0.
REQ-027 busy SHALL equal (state==EMIT).

Reset
REQ-028 rst=1 SHALL override all inputs, including start and abort.
REQ-029 rst=1 SHALL force IDLE, rk_valid=0, done=0, busy=0, rk_out=0 and rk_idx=0 on the next edge.
REQ-030 rst asserted mid-expansion SHALL discard progress; no stale rk_valid after reset.
REQ-031 Stored keys (REQ-032) SHALL reset to 0.

Configuration
REQ-032 With KEY_SCHED_STORE_EN defined: an 11x128 register file SHALL write rk_out at index rk_idx on every handshake. rd_key = entry[rd_idx] combinationally; rd_idx>10 SHALL read 0.
REQ-033 Without KEY_SCHED_STORE_EN: no storage SHALL be built, rd_key SHALL be tied to 0, and rd_idx SHALL be unused; all other behaviour is identical.

Verification
REQ-034 Start with key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c and rk_ready=1 -> rk_idx 0..10 on 11 consecutive cycles. idx1=a0fafe17_88542cb1_23a33939_2a6c7605; idx10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done pulses 1 cycle after idx10.
REQ-035 Same key with rk_ready low for 3 cycles at idx4 -> rk_out/rk_idx stable all 3 cycles; the sequence resumes with a correct idx5.
REQ-036 start pulsed during EMIT at idx3 with a different key_in -> sequence unaffected; the FIPS-197 values still appear.
REQ-037 abort at idx6 -> next cycle rk_valid=0, busy=0, done never asserted; a new start then produces idx0 = the new key_in.
REQ-038 rst asserted at idx8 -> next cycle rk_valid=0, rk_out=0, rk_idx=0, state IDLE.
REQ-039 With KEY_SCHED_STORE_EN after REQ-034 -> rd_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rd_idx=0 gives key_in; rd_idx=12 gives 0.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// ============================================================================
//  Module      : key_sched_ctrl
//  Description : AES-128 round-key expansion controller with valid/ready
//                streaming of round keys 0..10. Optional key store enabled
//                by defining KEY_SCHED_STORE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd10;

    // Row r of this table holds S-box entries 16*r .. 16*r+15, entry 0 at the MSB.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        f_sbox = c_sbox[{8'd255 - b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    f_rcon = 8'h01;
            4'd1:    f_rcon = 8'h02;
            4'd2:    f_rcon = 8'h04;
            4'd3:    f_rcon = 8'h08;
            4'd4:    f_rcon = 8'h10;
            4'd5:    f_rcon = 8'h20;
            4'd6:    f_rcon = 8'h40;
            4'd7:    f_rcon = 8'h80;
            4'd8:    f_rcon = 8'h1b;
            4'd9:    f_rcon = 8'h36;
            default: f_rcon = 8'h00;
        endcase
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_rk_out;
    logic [127:0]   w_rk_out_nxt;
    logic [3:0]     r_rk_idx;
    logic [3:0]     w_rk_idx_nxt;
    logic           r_rk_valid;
    logic           w_rk_valid_nxt;
    logic           w_hs;

    logic [31:0]    w_w0;
    logic [31:0]    w_w1;
    logic [31:0]    w_w2;
    logic [31:0]    w_w3;
    logic [31:0]    w_rot;
    logic [31:0]    w_g;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;
    logic [127:0]   w_next_key;

    assign w_hs = r_rk_valid & rk_ready;

    // Single g-function: the next round key is derived from the registered key only.
    assign w_w0  = r_rk_out[127:96];
    assign w_w1  = r_rk_out[95:64];
    assign w_w2  = r_rk_out[63:32];
    assign w_w3  = r_rk_out[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_g   = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                    f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])}
                 ^ {f_rcon(r_rk_idx), 24'h000000};
    assign w_n0  = w_w0 ^ w_g;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rk_out   <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rk_out   <= w_rk_out_nxt;
            r_rk_idx   <= w_rk_idx_nxt;
            r_rk_valid <= w_rk_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rk_out_nxt   = r_rk_out;
        w_rk_idx_nxt   = r_rk_idx;
        w_rk_valid_nxt = r_rk_valid;
        case (r_state)
            ST_IDLE: begin
                w_rk_valid_nxt = 1'b0;
                if (start && !abort) begin
                    w_rk_out_nxt   = key_in;
                    w_rk_idx_nxt   = 4'd0;
                    w_rk_valid_nxt = 1'b1;
                    w_state_nxt    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    w_rk_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (w_hs) begin
                    if (r_rk_idx < c_LAST_IDX) begin
                        w_rk_out_nxt = w_next_key;
                        w_rk_idx_nxt = r_rk_idx + 4'd1;
                    end else begin
                        w_rk_valid_nxt = 1'b0;
                        w_state_nxt    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_rk_valid_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_rk_valid_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    assign rk_valid = r_rk_valid;
    assign rk_out   = r_rk_out;
    assign rk_idx   = r_rk_idx;
    assign busy     = (r_state == ST_EMIT);
    assign done     = (r_state == ST_DONE);

`ifdef KEY_SCHED_STORE_EN
    logic [127:0] r_store [0:10];

    // A key aborted in the same cycle as its handshake is still stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_hs) begin
            for (int i = 0; i < 11; i++) begin
                if (r_rk_idx == 4'(i)) begin
                    r_store[i] <= r_rk_out;
                end
            end
        end
    end

    always_comb begin
        rd_key = '0;
        for (int i = 0; i < 11; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_key = r_store[i];
            end
        end
    end
`else
    logic w_rd_idx_unused;
    assign w_rd_idx_unused = ^rd_idx;
    assign rd_key          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
// ============================================================================
//  Module      : tb_key_sched_ctrl
//  Description : Directed self-checking bench for key_sched_ctrl using the
//                FIPS-197 A.1 key expansion vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_checks;
    int n_fail;

    logic [127:0] exp_rk [0:10];
    logic [127:0] c_key_a;
    logic [127:0] c_key_b;
    logic [127:0] exp_rd;

    key_sched_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_key(input int r);
        chk($sformatf("valid_idx%0d", r), {127'd0, rk_valid}, 128'd1);
        chk($sformatf("idx_idx%0d", r), {124'd0, rk_idx}, 128'(r));
        chk($sformatf("key_idx%0d", r), rk_out, exp_rk[r]);
    endtask

    // From IDLE: start the FIPS key and stream with rk_ready=1 up to round n.
    task automatic run_to(input int n);
        key_in = c_key_a;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        expect_key(0);
        for (int r = 1; r <= n; r++) begin
            tick();
            expect_key(r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        c_key_a  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        c_key_b  = 128'h00112233_44556677_8899aabb_ccddeeff;
        exp_rk[0]  = c_key_a;
        exp_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        exp_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        exp_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        exp_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        exp_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        exp_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        exp_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        exp_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        exp_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        exp_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
        rd_idx   = 4'd0;
        tick();
        tick();
        chk("rst_valid", {127'd0, rk_valid}, 128'd0);
        chk("rst_out",   rk_out, 128'd0);
        chk("rst_idx",   {124'd0, rk_idx}, 128'd0);
        chk("rst_busy",  {127'd0, busy}, 128'd0);
        chk("rst_done",  {127'd0, done}, 128'd0);
        chk("rst_rdkey", rd_key, 128'd0);
        rst = 1'b0;
        tick();

        // Full-throughput expansion
        run_to(10);
        chk("full_busy_idx10", {127'd0, busy}, 128'd1);
        tick();
        chk("full_done",       {127'd0, done}, 128'd1);
        chk("full_done_valid", {127'd0, rk_valid}, 128'd0);
        chk("full_done_busy",  {127'd0, busy}, 128'd0);
        tick();
        chk("full_done_clear", {127'd0, done}, 128'd0);
        chk("full_idle_valid", {127'd0, rk_valid}, 128'd0);
        chk("idle_hold_out",   rk_out, exp_rk[10]);

        rd_idx = 4'd10;
        #1;
`ifdef KEY_SCHED_STORE_EN
        exp_rd = exp_rk[10];
`else
        exp_rd = '0;
`endif
        chk("rd_idx10", rd_key, exp_rd);
        rd_idx = 4'd0;
        #1;
`ifdef KEY_SCHED_STORE_EN
        exp_rd = c_key_a;
`else
        exp_rd = '0;
`endif
        chk("rd_idx0", rd_key, exp_rd);
        rd_idx = 4'd12;
        #1;
        chk("rd_idx12", rd_key, 128'd0);

        // Backpressure for 3 cycles at idx4
        run_to(4);
        rk_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_key(4);
        end
        rk_ready = 1'b1;
        for (int r = 5; r <= 10; r++) begin
            tick();
            expect_key(r);
        end
        tick();
        chk("bp_done", {127'd0, done}, 128'd1);
        tick();

        // start with a different key while emitting is ignored
        run_to(3);
        start  = 1'b1;
        key_in = c_key_b;
        tick();
        start  = 1'b0;
        expect_key(4);
        for (int r = 5; r <= 10; r++) begin
            tick();
            expect_key(r);
        end
        tick();
        chk("ign_done", {127'd0, done}, 128'd1);
        tick();

        // abort at idx6
        run_to(6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {127'd0, rk_valid}, 128'd0);
        chk("abort_busy",  {127'd0, busy}, 128'd0);
        chk("abort_done",  {127'd0, done}, 128'd0);
        tick();
        chk("abort_done_later", {127'd0, done}, 128'd0);
        // abort beats start in IDLE
        key_in = c_key_b;
        start  = 1'b1;
        abort  = 1'b1;
        tick();
        abort  = 1'b0;
        chk("abort_start_valid", {127'd0, rk_valid}, 128'd0);
        chk("abort_start_busy",  {127'd0, busy}, 128'd0);
        tick();
        start  = 1'b0;
        chk("restart_valid", {127'd0, rk_valid}, 128'd1);
        chk("restart_idx",   {124'd0, rk_idx}, 128'd0);
        chk("restart_key",   rk_out, c_key_b);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // reset at idx8, with start asserted alongside
        run_to(8);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("midrst_valid", {127'd0, rk_valid}, 128'd0);
        chk("midrst_out",   rk_out, 128'd0);
        chk("midrst_idx",   {124'd0, rk_idx}, 128'd0);
        chk("midrst_busy",  {127'd0, busy}, 128'd0);
        chk("midrst_done",  {127'd0, done}, 128'd0);
        rd_idx = 4'd0;
        #1;
        chk("midrst_rdkey", rd_key, 128'd0);
        tick();
        chk("midrst_stay_idle", {127'd0, rk_valid}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
